mc_fetch_unit: RTL and testbench

- Instruction-fetch stage for the multi-cycle LoongArch core; sits directly upstream of decode/execute.
- Owns the architectural PC and drives the instruction SRAM, which has synchronous read (1-cycle latency).
- Presents one instruction at a time to decode through a valid/ready handshake.
- Computes the next PC only when the core reports commit, using the branch-taken flag and target.

---
 rtl/core_pkg.sv | 25 ++
 rtl/mc_npc_gen.sv | 19 +
 rtl/mc_fetch_unit.sv | 94 +++++++++
 tb/tb_mc_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core front end:
// fetch state encoding, reset PC and presented-instruction bundle.
package core_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_BUSY = 2'd3
    } fs_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam logic [31:0] NOP_INST     = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fs_out_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mc_npc_gen.sv
// Next-PC select for the fetch stage: sequential or redirect,
// plus the word-alignment check on the current PC.
module mc_npc_gen
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] npc,
    output logic        pc_adef
);

    logic [31:0] seq_pc;

    assign seq_pc  = pc + 32'd4;
    assign npc     = br_taken ? br_target : seq_pc;
    assign pc_adef = pc_misaligned(pc);

endmodule

// File: rtl/mc_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, reads the
// instruction SRAM and presents one instruction at a time to decode.
module mc_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_sram_en,
    output logic             inst_sram_we,
    output logic [31:0]      inst_sram_addr,
    output logic [31:0]      inst_sram_wdata,
    input  logic [31:0]      inst_sram_rdata,
    output logic             fs_valid,
    output logic [31:0]      fs_pc,
    output logic [31:0]      fs_inst,
    output logic             fs_adef,
    input  logic             ds_ready,
    input  logic             commit_valid,
    input  logic             commit_br_taken,
    input  logic [31:0]      commit_br_target,
    output logic [CNT_W-1:0] fetch_cnt
);

    fs_state_e   state;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pc_adef;
    fs_out_t     fs_out;
    logic        fs_vld;

    mc_npc_gen u_npc_gen (
        .pc        (pc),
        .br_taken  (commit_br_taken),
        .br_target (commit_br_target),
        .npc       (npc),
        .pc_adef   (pc_adef)
    );

    // A misaligned PC never reaches the SRAM; the fault is presented instead.
    assign inst_sram_en    = resetn & (state == FS_REQ) & ~pc_adef;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = pc;
    assign inst_sram_wdata = 32'd0;

    assign fs_valid = fs_vld;
    assign fs_pc    = fs_out.pc;
    assign fs_inst  = fs_out.inst;
    assign fs_adef  = fs_out.adef;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= FS_REQ;
            pc        <= RESET_PC;
            fs_vld    <= 1'b0;
            fs_out    <= '0;
            fetch_cnt <= '0;
        end else begin
            unique case (state)
                FS_REQ: begin
                    if (pc_adef) begin
                        fs_out <= '{pc: pc, inst: 32'd0, adef: 1'b1};
                        fs_vld <= 1'b1;
                        state  <= FS_HOLD;
                    end else begin
                        state  <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    fs_out <= '{pc: pc, inst: inst_sram_rdata, adef: 1'b0};
                    fs_vld <= 1'b1;
                    state  <= FS_HOLD;
                end
                FS_HOLD: begin
                    if (ds_ready) begin
                        fs_vld    <= 1'b0;
                        fetch_cnt <= fetch_cnt + CNT_W'(1);
                        state     <= FS_BUSY;
                    end
                end
                FS_BUSY: begin
                    if (commit_valid) begin
                        pc    <= npc;
                        state <= FS_REQ;
                    end
                end
                default: state <= FS_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Scoreboard bench for mc_fetch_unit: expected fetches are queued
// when the PC is set up and checked when decode sees them.
module tb_mc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;
    logic        ds_ready;
    logic        commit_valid;
    logic        commit_br_taken;
    logic [31:0] commit_br_target;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    mc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_we     (inst_sram_we),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .fs_valid         (fs_valid),
        .fs_pc            (fs_pc),
        .fs_inst          (fs_inst),
        .fs_adef          (fs_adef),
        .ds_ready         (ds_ready),
        .commit_valid     (commit_valid),
        .commit_br_taken  (commit_br_taken),
        .commit_br_target (commit_br_target),
        .fetch_cnt        (fetch_cnt)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0280_0421;
        return (a ^ 32'h5a5a_0000) + 32'h13;
    endfunction

    always @(posedge clk)
        if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc   = exp_pc;
        e.adef = (exp_pc[1:0] != 2'b00);
        e.inst = e.adef ? 32'd0 : sram_word(exp_pc);
        sb.push_back(e);
    endtask

    task automatic do_commit(input logic taken, input logic [31:0] target);
        commit_valid     = 1'b1;
        commit_br_taken  = taken;
        commit_br_target = target;
        exp_pc = taken ? target : exp_pc + 32'd4;
        push_exp();
        @(posedge clk);
        @(negedge clk);
        commit_valid    = 1'b0;
        commit_br_taken = 1'b0;
        check("req_en", 32'(inst_sram_en), 32'(exp_pc[1:0] == 2'b00));
        check("req_addr", inst_sram_addr, exp_pc);
    endtask

    task automatic present(input int hold, input bit pulse);
        int   n;
        exp_t e;
        n = 0;
        while (!fs_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("valid", 32'(fs_valid), 32'd1);
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("latency", 32'(n), e.adef ? 32'd1 : 32'd2);
        check("fs_pc", fs_pc, e.pc);
        check("fs_inst", fs_inst, e.inst);
        check("fs_adef", 32'(fs_adef), 32'(e.adef));
        for (int i = 0; i < hold; i++) begin
            commit_valid     = pulse;
            commit_br_taken  = pulse;
            commit_br_target = 32'hdead_beec;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(fs_valid), 32'd1);
            check("hold_pc", fs_pc, e.pc);
            check("hold_inst", fs_inst, e.inst);
            check("hold_en", 32'(inst_sram_en), 32'd0);
        end
        commit_valid    = 1'b0;
        commit_br_taken = 1'b0;
        ds_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds_ready = 1'b0;
        exp_cnt  = exp_cnt + 32'd1;
        check("hs_valid", 32'(fs_valid), 32'd0);
        check("fetch_cnt", fetch_cnt, exp_cnt);
        check("busy_en", 32'(inst_sram_en), 32'd0);
    endtask

    initial begin
        resetn           = 1'b0;
        ds_ready         = 1'b0;
        commit_valid     = 1'b0;
        commit_br_taken  = 1'b0;
        commit_br_target = 32'd0;
        exp_cnt          = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(fs_valid), 32'd0);
        check("rst_pc", fs_pc, 32'd0);
        check("rst_inst", fs_inst, 32'd0);
        check("rst_adef", 32'(fs_adef), 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_en", 32'(inst_sram_en), 32'd0);
        check("we", 32'(inst_sram_we), 32'd0);
        check("wdata", inst_sram_wdata, 32'd0);

        resetn = 1'b1;
        exp_pc = RST_PC;
        push_exp();
        #1;
        check("first_en", 32'(inst_sram_en), 32'd1);
        check("first_addr", inst_sram_addr, RST_PC);
        present(5, 1'b0);

        do_commit(1'b0, 32'h0);
        present(0, 1'b0);
        do_commit(1'b1, 32'h1c00_0100);
        present(3, 1'b1);
        do_commit(1'b0, 32'h0);
        present(1, 1'b0);

        do_commit(1'b1, 32'h1c00_0102);
        present(2, 1'b0);

        do_commit(1'b1, 32'hffff_fffc);
        present(0, 1'b0);
        do_commit(1'b0, 32'h0);
        present(0, 1'b0);

        do_commit(1'b1, 32'h1c00_0200);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", 32'(fs_valid), 32'd0);
        check("abort_cnt", fetch_cnt, 32'd0);
        check("abort_en", 32'(inst_sram_en), 32'd0);
        check("abort_addr", inst_sram_addr, RST_PC);
        sb.delete();
        exp_cnt = 32'd0;
        exp_pc  = RST_PC;
        resetn  = 1'b1;
        push_exp();
        #1;
        check("rearm_en", 32'(inst_sram_en), 32'd1);
        present(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
